// File: rtl/uart_bridge.sv
// uart_bridge
//   Responder end of the io-unit UART handshake. A 1-4 byte word request is
//   turned into byte transfers on a byte-wide tx/rx link to the UART PHY.
//   Writes stream the latched word out little-endian on tx. Reads pop bytes
//   from an rx FIFO that buffers everything the PHY receives.
//
// Ports
//   clk, rstn          clock, synchronous active-low reset
//   uart_order         request from the io unit
//   uart_accepted      request taken this cycle (combinational)
//   uart_done          one-cycle completion pulse
//   uart_write_flag    1 = write (send), 0 = read (receive)
//   uart_size          byte count minus 1
//   uart_o_data        word to send, byte 0 in bits [7:0]
//   uart_i_data        assembled received word
//   tx_data/tx_valid   byte offered to the PHY transmitter
//   tx_ready           PHY takes the byte when tx_valid & tx_ready
//   rx_data/rx_valid   byte strobe from the PHY receiver (no backpressure)
//   rx_count           bytes currently held in the rx FIFO
//   rx_overflow        sticky: a received byte was dropped on a full FIFO

module uart_bridge #(
  parameter int RX_DEPTH     = 16,
  parameter int LOG_RX_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    uart_order,
  output logic                    uart_accepted,
  output logic                    uart_done,
  input  logic                    uart_write_flag,
  input  logic [1:0]              uart_size,
  input  logic [31:0]             uart_o_data,
  output logic [31:0]             uart_i_data,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [LOG_RX_DEPTH:0]   rx_count,
  output logic                    rx_overflow
);

  typedef enum logic [1:0] {IDLE, TX, RX, DONE} state_t;

  state_t                  state, state_next;
  logic [1:0]              cnt;        // byte index within the current request
  logic [1:0]              last_idx;   // nbytes - 1
  logic [31:0]             word;       // latched write data
  logic [31:0]             i_data;

  logic [7:0]              mem [RX_DEPTH];
  logic [LOG_RX_DEPTH-1:0] wptr, rptr;
  logic [LOG_RX_DEPTH:0]   count;
  logic                    overflow;

  logic                    last;
  logic                    full;
  logic                    pop;
  logic                    push;
  logic [7:0]              rd_byte;

  assign last    = (cnt == last_idx);
  assign full    = (count == (LOG_RX_DEPTH+1)'(RX_DEPTH));
  assign pop     = (state == RX) && (count != '0);
  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign push    = rx_valid && (!full || pop);
  assign rd_byte = mem[rptr];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_next    = state;
    uart_accepted = 1'b0;
    unique case (state)
      IDLE: if (uart_order) begin
        uart_accepted = 1'b1;
        state_next    = uart_write_flag ? TX : RX;
      end
      TX:   if (tx_ready && last) state_next = DONE;
      RX:   if (pop && last)      state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign uart_done   = (state == DONE);
  assign tx_valid    = (state == TX);
  // Driven only while offering a byte, so it reads 0 in reset and idle.
  assign tx_data     = tx_valid ? word[{cnt, 3'b000} +: 8] : 8'h00;
  assign uart_i_data = i_data;
  assign rx_count    = count;
  assign rx_overflow = overflow;

  // ---------------------------------------------------------------------------
  // Request datapath: latched word, byte counter, read assembly
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt      <= '0;
      last_idx <= '0;
      word     <= '0;
      i_data   <= '0;
    end else begin
      if (uart_accepted) begin
        word     <= uart_o_data;
        last_idx <= uart_size;
        cnt      <= '0;
      end

      if (state == TX && tx_ready && !last) cnt <= cnt + 2'd1;

      if (pop) begin
        // The first pop of a read clears the stale upper bytes of the word.
        if (cnt == 2'd0) i_data <= {24'h0, rd_byte};
        else             i_data[{cnt, 3'b000} +: 8] <= rd_byte;
        if (!last) cnt <= cnt + 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // rx FIFO
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; emptiness is defined by the pointers
  // and occupancy, so clearing the contents would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (rstn && push) mem[wptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + LOG_RX_DEPTH'(1);
      if (pop)  rptr <= rptr + LOG_RX_DEPTH'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (LOG_RX_DEPTH+1)'(1);
        2'b01:   count <= count - (LOG_RX_DEPTH+1)'(1);
        default: count <= count;
      endcase
      if (rx_valid && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_bridge.sv
// tb_uart_bridge
//   Directed bench for uart_bridge. Expected tx bytes, operation kinds and
//   read words are queued when a request is issued; a negedge monitor pops
//   and compares them as the bridge produces tx handshakes and done pulses.
//   A byte-queue model of the rx FIFO supplies expected read data.

module tb_uart_bridge;

  localparam int RX_DEPTH     = 16;
  localparam int LOG_RX_DEPTH = 4;

  logic                  clk;
  logic                  rstn;
  logic                  uart_order;
  logic                  uart_accepted;
  logic                  uart_done;
  logic                  uart_write_flag;
  logic [1:0]            uart_size;
  logic [31:0]           uart_o_data;
  logic [31:0]           uart_i_data;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [LOG_RX_DEPTH:0] rx_count;
  logic                  rx_overflow;

  uart_bridge #(.RX_DEPTH(RX_DEPTH), .LOG_RX_DEPTH(LOG_RX_DEPTH)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .uart_order      (uart_order),
    .uart_accepted   (uart_accepted),
    .uart_done       (uart_done),
    .uart_write_flag (uart_write_flag),
    .uart_size       (uart_size),
    .uart_o_data     (uart_o_data),
    .uart_i_data     (uart_i_data),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_count        (rx_count),
    .rx_overflow     (rx_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  logic [7:0]  exp_tx[$];   // bytes expected on tx, in order
  bit          exp_op[$];   // 1 = read, 0 = write, per accepted request
  logic [31:0] exp_rd[$];   // words expected at read completion
  logic [7:0]  model[$];    // model of rx FIFO contents

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One-cycle rx strobe; the model keeps only bytes a 16-deep FIFO can hold.
  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    if (model.size() < RX_DEPTH) model.push_back(b);
    tick();
    rx_valid = 1'b0;
  endtask

  function automatic logic [31:0] model_pop(input int n);
    logic [31:0] w = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = model.pop_front();
    return w;
  endfunction

  // Issue a write; returns in the cycle after acceptance.
  task automatic do_write(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] d = data;
    for (int i = 0; i <= int'(size); i++) exp_tx.push_back(d[8*i +: 8]);
    exp_op.push_back(1'b0);
    uart_order      = 1'b1;
    uart_write_flag = 1'b1;
    uart_size       = size;
    uart_o_data     = data;
    #1;
    check("write_accepted", uart_accepted, 1'b1);
    tick();
    uart_order = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] size, input logic [31:0] expected);
    exp_op.push_back(1'b1);
    exp_rd.push_back(expected);
    uart_order      = 1'b1;
    uart_write_flag = 1'b0;
    uart_size       = size;
    uart_o_data     = 32'hDEAD_BEEF;
    #1;
    check("read_accepted", uart_accepted, 1'b1);
    tick();
    uart_order = 1'b0;
  endtask

  // Bounded wait for done; n = cycles waited after the first post-accept cycle.
  task automatic wait_done(input int max_cycles, output int n);
    n = 0;
    while (!uart_done && n < max_cycles) begin
      tick();
      n++;
    end
    check("done_timeout", uart_done, 1'b1);
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (tx_valid && tx_ready) begin
        check("tx_extra_byte", exp_tx.size() != 0, 1'b1);
        if (exp_tx.size() != 0) check("tx_byte", tx_data, exp_tx.pop_front());
      end
      if (uart_done) begin
        done_cnt++;
        check("done_expected", exp_op.size() != 0, 1'b1);
        if (exp_op.size() != 0 && exp_op.pop_front()) begin
          check("rd_queue", exp_rd.size() != 0, 1'b1);
          if (exp_rd.size() != 0) check("rd_data", uart_i_data, exp_rd.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    int d0;
    logic [31:0] w;

    rstn            = 1'b0;
    uart_order      = 1'b0;
    uart_write_flag = 1'b0;
    uart_size       = 2'd0;
    uart_o_data     = 32'h0;
    tx_ready        = 1'b0;
    rx_data         = 8'h0;
    rx_valid        = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    check("rst_accepted", uart_accepted, 1'b0);
    check("rst_done",     uart_done,     1'b0);
    check("rst_tx_valid", tx_valid,      1'b0);
    check("rst_tx_data",  tx_data,       8'h00);
    check("rst_i_data",   uart_i_data,   32'h0);
    check("rst_rx_count", rx_count,      5'd0);
    check("rst_overflow", rx_overflow,   1'b0);
    rstn = 1'b1;
    tick();

    // ---- write 4 bytes, tx_ready held high ----
    tx_ready = 1'b1;
    w = 32'hA1B2C3D4;
    do_write(2'd3, w);
    for (int k = 0; k < 4; k++) begin
      check("w4_tx_valid", tx_valid, 1'b1);
      check("w4_tx_data",  tx_data,  w[8*k +: 8]);
      check("w4_no_done",  uart_done, 1'b0);
      tick();
    end
    check("w4_done",        uart_done, 1'b1);
    check("w4_done_no_tx",  tx_valid,  1'b0);
    tick();
    check("w4_done_pulse",  uart_done, 1'b0);

    // ---- write with backpressure ----
    tx_ready = 1'b0;
    d0 = done_cnt;
    do_write(2'd1, 32'h0000_5A3C);
    for (int k = 0; k < 3; k++) begin
      check("bp_tx_valid", tx_valid, 1'b1);
      check("bp_tx_stall", tx_data,  8'h3C);
      tick();
    end
    tx_ready = 1'b1;
    check("bp_tx_first", tx_data, 8'h3C);
    tick();
    check("bp_tx_second", tx_data, 8'h5A);
    wait_done(10, n);
    repeat (4) tick();
    check("bp_done_count", done_cnt - d0, 1);
    check("bp_tx_idle",    tx_valid,      1'b0);

    // ---- read 2 bytes, data present ----
    send_rx(8'h11);
    send_rx(8'h22);
    check("rd2_count_before", rx_count, 5'd2);
    do_read(2'd1, model_pop(2));
    wait_done(20, n);
    check("rd2_latency",     n,           2);
    check("rd2_i_data",      uart_i_data, 32'h0000_2211);
    check("rd2_count_after", rx_count,    5'd0);
    tick();

    // ---- read stall on an empty FIFO ----
    do_read(2'd2, 32'h0003_0201);
    for (int b = 1; b <= 3; b++) begin
      repeat (5) begin
        check("stall_no_done", uart_done, 1'b0);
        tick();
      end
      rx_valid = 1'b1;
      rx_data  = 8'(b);
      tick();
      rx_valid = 1'b0;
    end
    check("stall_no_done_at_pop", uart_done, 1'b0);
    check("stall_count_at_pop",   rx_count,  5'd1);
    tick();
    check("stall_done",   uart_done,   1'b1);
    check("stall_i_data", uart_i_data, 32'h0003_0201);
    tick();
    check("stall_count_empty", rx_count, 5'd0);

    // ---- overflow, then pointer wrap ----
    for (int i = 0; i < 17; i++) send_rx(8'h40 + 8'(i));
    check("ovf_count", rx_count,    5'd16);
    check("ovf_flag",  rx_overflow, 1'b1);
    do_read(2'd3, model_pop(4));
    wait_done(20, n);
    check("ovf_rd_data", uart_i_data, 32'h4342_4140);
    tick();
    for (int it = 0; it < 5; it++) begin
      for (int j = 0; j < 4; j++) send_rx(8'h80 + 8'(it*4 + j));
      check("wrap_count_full", rx_count, 5'd16);
      do_read(2'd3, model_pop(4));
      wait_done(20, n);
      check("wrap_latency", n, 4);
      tick();
    end
    check("wrap_count",    rx_count,    5'd12);
    check("wrap_ovf_held", rx_overflow, 1'b1);

    // ---- reset during TX byte 1 ----
    tx_ready = 1'b1;
    d0 = done_cnt;
    do_write(2'd3, 32'h1122_3344);
    tick();
    check("rst_mid_byte1", tx_data, 8'h33);
    rstn = 1'b0;
    exp_tx.delete();
    exp_op.delete();
    model.delete();
    tick();
    check("rst_mid_tx_valid", tx_valid,    1'b0);
    check("rst_mid_done",     uart_done,   1'b0);
    check("rst_mid_count",    rx_count,    5'd0);
    check("rst_mid_overflow", rx_overflow, 1'b0);
    rstn = 1'b1;
    tick();
    check("rst_mid_no_done", done_cnt - d0, 0);
    do_write(2'd0, 32'h0000_0077);
    wait_done(10, n);
    check("post_rst_latency", n, 1);
    tick();
    tick();
    check("post_rst_done_count", done_cnt - d0, 1);
    check("tx_queue_drained",    exp_tx.size(), 0);
    check("rd_queue_drained",    exp_rd.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_bridge.md
Name: uart_bridge

Overview:
- Responder end of the core's io-unit UART handshake (uart_order / uart_accepted / uart_done).
- Converts a 1–4 byte word request from the io unit into byte transfers on a byte-wide tx/rx link to the UART PHY.
- Holds received bytes in an rx FIFO. Reads are served from the FIFO; writes stream bytes out little-endian.

Parameters:
- RX_DEPTH, 16, rx FIFO depth in bytes; must be a power of 2 and at least 4.
- LOG_RX_DEPTH, 4, log2(RX_DEPTH); pointer width.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- uart_order  in  1  request from io unit
- uart_accepted  out  1  request taken this cycle
- uart_done  out  1  one-cycle completion pulse
- uart_write_flag  in  1  1 = write (send), 0 = read (receive)
- uart_size  in  2  byte count minus 1 (0 → 1 byte … 3 → 4 bytes)
- uart_o_data  in  32  word to send; byte 0 = bits [7:0]
- uart_i_data  out  32  assembled received word
- tx_data  out  8  byte to PHY transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  PHY accepts byte when tx_valid & tx_ready
- rx_data  in  8  byte from PHY receiver
- rx_valid  in  1  one-cycle strobe; no backpressure
- rx_count  out  LOG_RX_DEPTH+1  bytes currently in FIFO
- rx_overflow  out  1  sticky; a received byte was dropped

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is synchronous, active-low, and dominates everything.
- Reset state:
  - state = IDLE; FIFO empty with pointers 0; rx_count = 0.
  - uart_accepted, uart_done, tx_valid, rx_overflow = 0.
  - tx_data = 0, uart_i_data = 0.
- Reset mid-operation: any in-flight request is aborted with no done pulse. A byte being offered on tx is withdrawn.
- States are IDLE, TX, RX and DONE.
- Acceptance (IDLE):
  - uart_accepted = uart_order & (state == IDLE). It is combinational, so the io unit may depend on it in the same cycle.
  - On accept, latch write_flag, nbytes = uart_size + 1 and uart_o_data; clear byte counter cnt.
  - Next state is TX if write_flag = 1, otherwise RX.
  - uart_order in any state other than IDLE is ignored and not queued.
- TX state:
  - tx_valid = 1 and tx_data = latched word byte cnt, i.e. bits [8*cnt+7 : 8*cnt].
  - On tx_valid & tx_ready: if cnt == nbytes-1, go to DONE; otherwise cnt++.
  - tx_data is stable while tx_valid & ~tx_ready.
- RX state:
  - When the FIFO is non-empty, pop one byte per cycle into assembly byte cnt.
  - After the pop of byte nbytes-1, go to DONE.
  - An empty FIFO stalls indefinitely, with no timeout.
  - uart_i_data is rewritten on the first pop: byte 0 written, all other bytes cleared. Later pops fill bytes 1..3 in order. For nbytes < 4 the upper bytes are 0.
- DONE state:
  - uart_done = 1 for exactly one cycle, then IDLE.
  - uart_i_data is valid in the DONE cycle and held until the first pop of the next read.
  - Writes leave uart_i_data unchanged.
- Latency:
  - Write with tx_ready held 1: done at accept + nbytes + 1 cycles.
  - Read with at least nbytes already buffered: same latency, done at accept + nbytes + 1.
- rx FIFO:
  - Push on rx_valid in any state except during reset; pop only in RX.
  - Pointers are LOG_RX_DEPTH bits and wrap modulo RX_DEPTH.
  - rx_count is the registered occupancy, and always equals the number of bytes in the FIFO.
  - Full with rx_valid and no pop in the same cycle: the byte is dropped, rx_overflow is set and stays 1 until reset.
  - Full with rx_valid and a pop in the same cycle: the push succeeds and the count is unchanged.
  - Empty: no pop. A push while empty makes the byte poppable the next cycle (no same-cycle bypass).
- Ordering: bytes leave the FIFO in arrival order. Received byte k of a request maps to word bits [8k+7 : 8k].

Test Plan:
- Write 4 bytes:
  - Stimulus: reset; order with write=1, size=3, o_data=0xA1B2C3D4, tx_ready held 1.
  - Required: accepted in cycle 0; tx bytes D4, C3, B2, A1 in cycles 1–4; done in cycle 5 only.
- Write with backpressure:
  - Stimulus: size=1, o_data=0x00005A3C; tx_ready low for 3 cycles after tx_valid rises.
  - Required: tx_data stays 3C while stalled, then 5A; exactly one done pulse; no extra bytes.
- Read 2 bytes, data present:
  - Stimulus: rx strobes 0x11 then 0x22, then order with write=0, size=1.
  - Required: i_data = 0x00002211 in the done cycle; rx_count goes 2 → 0.
- Read stall:
  - Stimulus: order a 3-byte read with the FIFO empty; send bytes 0x01, 0x02, 0x03 spaced 5 cycles apart.
  - Required: no done until the cycle after the third byte is popped; i_data = 0x00030201.
- Overflow:
  - Stimulus: 17 rx strobes with no read.
  - Required: rx_count = 16; rx_overflow = 1; a following 4-byte read returns the first 4 bytes in order.
  - Required: pointers wrap correctly after 20 further push/pop bytes.
- Reset mid-write:
  - Stimulus: assert rstn = 0 during TX byte 1.
  - Required: next cycle tx_valid = 0 and no done pulse; FIFO empty; a new order is accepted immediately after rstn = 1.
